// File: rtl/dbus_uncached_responder_pkg.sv
// Shared bus types for the uncached data-bus responder: requester-side dbus and
// single-beat cbus request/response structs.
package dbus_uncached_responder_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'b0000,
    MLEN2  = 4'b0001,
    MLEN4  = 4'b0011,
    MLEN8  = 4'b0111,
    MLEN16 = 4'b1111
  } mlen_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;   // all-zero strobe marks a read
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic    valid;
    logic    is_write;
    msize_t  size;
    addr_t   addr;
    strobe_t strobe;
    word_t   data;
    mlen_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

endpackage

// File: rtl/dbus_uncached_responder_if.sv
// Bundles the requester-facing dbus pair and the memory-facing cbus pair;
// the responder takes the slave view, the requester/bus model the master view.
interface dbus_uncached_responder_if;
  import dbus_uncached_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport slave  (input  dreq, cresp, output dresp, creq);
  modport master (output dreq, cresp, input  dresp, creq);
endinterface

// File: rtl/dbus_uncached_responder.sv
// Uncached (MMIO / kseg1) data-bus responder: one outstanding request, one
// single-beat cbus transaction per request, optional watchdog abort.
module dbus_uncached_responder
  import dbus_uncached_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA       = 32'hdead_beef
) (
  input  logic                        clk,
  input  logic                        reset,
  dbus_uncached_responder_if.slave    bus,
  output logic                        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;

  addr_t       addr_q;
  msize_t      size_q;
  strobe_t     strobe_q;
  word_t       wdata_q;
  logic        write_q;
  word_t       rdata_q;
  logic        err_q;
  logic [31:0] wd_cnt;

  logic        bus_done;
  logic        wd_fire;

  assign bus_done = bus.cresp.ready && bus.cresp.last;
  // wd_cnt counts completed BUSY cycles, so this fires during the last allowed one.
  assign wd_fire  = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: each combinational block assigns a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.dreq.valid) state_next = BUSY;
      BUSY:    if (bus_done || wd_fire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dreq.valid) begin
            addr_q   <= bus.dreq.addr;
            size_q   <= bus.dreq.size;
            strobe_q <= bus.dreq.strobe;
            wdata_q  <= bus.dreq.data;
            write_q  <= |bus.dreq.strobe;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 32'd1;
          // A real completion outranks a watchdog expiry in the same cycle.
          if (bus_done) begin
            rdata_q <= bus.cresp.data;
            err_q   <= 1'b0;
          end else if (wd_fire) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          wd_cnt <= '0;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs depend on state only, so a stray cresp or changing dreq cannot leak through.
  always_comb begin
    bus.creq  = '0;
    bus.dresp = '0;
    bus_err   = 1'b0;
    case (state)
      BUSY: begin
        bus.creq.valid    = 1'b1;
        bus.creq.is_write = write_q;
        bus.creq.size     = size_q;
        bus.creq.addr     = addr_q;
        bus.creq.strobe   = strobe_q;
        bus.creq.data     = wdata_q;
        bus.creq.len      = MLEN1;
      end
      DONE: begin
        bus.dresp.addr_ok = 1'b1;
        bus.dresp.data_ok = 1'b1;
        bus.dresp.data    = rdata_q;
        bus_err           = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Directed bench for dbus_uncached_responder: reads, writes, back-to-back,
// watchdog abort and corner, stray responses and mid-operation reset.
module tb_dbus_uncached_responder;
  import dbus_uncached_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic bus_err;

  int n_checks = 0;
  int n_errors = 0;

  dbus_uncached_responder_if bus ();

  dbus_uncached_responder #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request (cycle 1 = cycle the request is first visible) and
  // plays the cbus slave. ready_at is the BUSY cycle giving ready/last (0 = never).
  task automatic do_txn(input string tag, input logic [31:0] addr, input msize_t size,
                        input logic [3:0] strobe, input logic [31:0] wdata,
                        input int ready_at, input logic [31:0] sdata,
                        input bit hold, input bit stray, input bit scramble,
                        input int exp_dok, input int exp_busy,
                        input logic [31:0] exp_rdata, input logic exp_err);
    cbus_req_t   first;
    bit          got_first = 1'b0;
    bit          unstable  = 1'b0;
    int          busy_n    = 0;
    int          dok_at    = 0;
    logic [31:0] rdata     = '0;
    logic        err       = 1'b0;
    first = '0;
    bus.dreq  = '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: wdata};
    bus.cresp = '0;
    for (int cyc = 2; cyc <= 40 && dok_at == 0; cyc++) begin
      tick();
      bus.cresp = '0;
      if (bus.dresp.data_ok) begin
        dok_at = cyc;
        rdata  = bus.dresp.data;
        err    = bus_err;
        check({tag, " addr_ok"}, 32'(bus.dresp.addr_ok), 32'd1);
        check({tag, " creq_valid_in_done"}, 32'(bus.creq.valid), 32'd0);
        if (!hold) bus.dreq.valid = 1'b0;
      end else if (bus.creq.valid) begin
        busy_n++;
        if (!got_first) begin
          first     = bus.creq;
          got_first = 1'b1;
        end else if (bus.creq !== first) begin
          unstable = 1'b1;
        end
        if (busy_n == ready_at) bus.cresp = '{ready: 1'b1, last: 1'b1, data: sdata};
        else if (stray)         bus.cresp = '{ready: 1'b1, last: 1'b0, data: ~sdata};
        if (scramble) begin
          bus.dreq.addr   = ~addr;
          bus.dreq.data   = ~wdata;
          bus.dreq.strobe = ~strobe;
        end
      end
    end
    check({tag, " latency"}, dok_at, exp_dok);
    check({tag, " busy_cycles"}, busy_n, exp_busy);
    check({tag, " stable"}, 32'(unstable), 32'd0);
    check({tag, " is_write"}, 32'(first.is_write), 32'(|strobe));
    check({tag, " addr"}, first.addr, addr);
    check({tag, " size"}, 32'(first.size), 32'(size));
    check({tag, " strobe"}, 32'(first.strobe), 32'(strobe));
    check({tag, " wdata"}, first.data, wdata);
    check({tag, " len"}, 32'(first.len), 32'(MLEN1));
    if (strobe == 4'b0000) check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " bus_err"}, 32'(err), 32'(exp_err));
    if (!hold) begin
      tick();
      check({tag, " data_ok_once"}, 32'(bus.dresp.data_ok), 32'd0);
      check({tag, " idle_creq"}, 32'(bus.creq.valid), 32'd0);
      check({tag, " idle_bus_err"}, 32'(bus_err), 32'd0);
    end
  endtask

  initial begin
    bit bad;
    reset     = 1'b1;
    bus.dreq  = '0;
    bus.cresp = '0;
    tick();
    tick();
    check("reset creq", 32'(|bus.creq), 32'd0);
    check("reset dresp", 32'(|bus.dresp), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    tick();

    // Read, slave answers in the 2nd BUSY cycle: data_ok in cycle 4.
    do_txn("read", 32'h1FD0_03F8, MSIZE4, 4'b0000, 32'h0, 2, 32'h0000_0041,
           1'b0, 1'b0, 1'b0, 4, 2, 32'h0000_0041, 1'b0);

    // Byte write with immediate ready/last: data_ok in cycle 3.
    do_txn("bwrite", 32'h1FAF_F002, MSIZE1, 4'b0100, 32'h00AB_0000, 1, 32'h0,
           1'b0, 1'b0, 1'b0, 3, 1, 32'h0, 1'b0);

    // dreq scrambled during BUSY must not disturb the latched request.
    do_txn("scramble", 32'h1FD0_0010, MSIZE2, 4'b0000, 32'h0000_0000, 3, 32'h1234_5678,
           1'b0, 1'b0, 1'b1, 5, 3, 32'h1234_5678, 1'b0);

    // Back-to-back with valid held; second request appears in the DONE cycle,
    // so it passes through one IDLE cycle before BUSY.
    do_txn("b2b_first", 32'h1FD0_0000, MSIZE4, 4'b0000, 32'h0, 1, 32'hAAAA_0001,
           1'b1, 1'b0, 1'b0, 3, 1, 32'hAAAA_0001, 1'b0);
    do_txn("b2b_second", 32'h1FD0_0004, MSIZE4, 4'b0000, 32'h0, 1, 32'h5555_0002,
           1'b0, 1'b0, 1'b0, 4, 1, 32'h5555_0002, 1'b0);

    // Watchdog: no ready for 8 BUSY cycles -> error data and bus_err.
    do_txn("watchdog", 32'h1FD0_0020, MSIZE4, 4'b0000, 32'h0, 0, 32'h0,
           1'b0, 1'b0, 1'b0, 10, 8, 32'hdead_beef, 1'b1);

    // ready/last in the very cycle the watchdog expires: real data wins.
    do_txn("wd_corner", 32'h1FD0_0024, MSIZE4, 4'b0000, 32'h0, 8, 32'hCAFE_F00D,
           1'b0, 1'b0, 1'b0, 10, 8, 32'hCAFE_F00D, 1'b0);

    // Stray ready/last while IDLE must not start or complete anything.
    bad = 1'b0;
    bus.dreq  = '0;
    bus.cresp = '{ready: 1'b1, last: 1'b1, data: 32'hFFFF_0000};
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.creq.valid || bus.dresp.data_ok) bad = 1'b1;
    end
    check("stray_idle", 32'(bad), 32'd0);

    // ready without last in BUSY is ignored until the real last beat.
    do_txn("stray_busy", 32'h1FD0_0030, MSIZE4, 4'b0000, 32'h0, 4, 32'h600D_0004,
           1'b0, 1'b1, 1'b0, 6, 4, 32'h600D_0004, 1'b0);

    // Reset during the 3rd BUSY cycle.
    bus.cresp = '0;
    bus.dreq  = '{valid: 1'b1, addr: 32'h1FD0_0040, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    tick();
    check("rstmid busy1", 32'(bus.creq.valid), 32'd1);
    tick();
    tick();
    check("rstmid busy3", 32'(bus.creq.valid), 32'd1);
    reset = 1'b1;
    tick();
    check("rstmid creq", 32'(bus.creq.valid), 32'd0);
    check("rstmid dresp", 32'(|bus.dresp), 32'd0);
    reset         = 1'b0;
    bus.dreq.valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.dresp.data_ok || bus.creq.valid) bad = 1'b1;
    end
    check("rstmid no_data_ok", 32'(bad), 32'd0);

    do_txn("after_reset", 32'h1FD0_0044, MSIZE4, 4'b0000, 32'h0, 1, 32'h7777_8888,
           1'b0, 1'b0, 1'b0, 3, 1, 32'h7777_8888, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
